sha256_stream: RTL and testbench
================================

SHA256_STREAM -- requirements
Module: sha256_stream

Interface
REQ-001 The block SHALL have parameter BYTE_SWAP, default 1: 1 = din carries bytes little-endian and is byte-reversed before use; 0 = din is used as-is (big-endian).
REQ-002 The block SHALL have parameter SHA224, default 0: 1 = SHA-224 initial values and 224-bit digest; 0 = SHA-256.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  rising-edge clock for all state.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: din_valid  in  1  input word valid.
REQ-007 Port: din_ready  out  1  block can accept a word this cycle.
REQ-008 Port: din  in  32  message word; a 512-bit block is 16 words, W0 first.
REQ-009 Port: first  in  1  sampled with W0 only; 1 = start a new message (chaining value := IV).
REQ-010 Port: last  in  1  sampled with W0 only; 1 = this block ends the message.
REQ-011 Port: digest  out  256  {H0..H7}, with H0 in bits [255:224].
REQ-012 Port: digest_valid  out  1  level; digest holds a completed message hash.
REQ-013 Port: busy  out  1  high while compressing or updating.
REQ-014 Port: done  out  1  one-cycle pulse when a last block completes.

Function
REQ-015 A word SHALL transfer only on a cycle where din_valid and din_ready are both high; there is no combinational path from din_valid to din_ready.
REQ-016 The FSM SHALL have the states IDLE, LOAD, PROC and UPDATE, with these transitions:
- IDLE -> LOAD on W0 transfer.
- LOAD -> PROC on W15 transfer.
- PROC -> UPDATE after 64 rounds.
- UPDATE -> IDLE.
REQ-017 din_ready SHALL be 1 in IDLE and LOAD and 0 in PROC and UPDATE; busy SHALL be 1 in PROC and UPDATE only.
REQ-018 In LOAD, gaps with din_valid=0 SHALL stall the 4-bit word counter without loss; no timeout applies.
REQ-019 Words SHALL be stored into a 16x32 sliding window.
- PROC round t (0..63) SHALL use W[t] and K[t].
- For t>=16: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32.
- The K constants are held in an internal 64x32 table.
REQ-020 Working variables a..h SHALL be loaded at W0 transfer from the chaining value (IV if first=1, else current H0..H7).
- One FIPS 180-4 round SHALL be performed per PROC cycle.
- All additions SHALL be modulo 2^32.
REQ-021 In UPDATE, Hi SHALL become Hi + working variable i (mod 2^32) for i = 0..7.
REQ-022 Latency: if W15 transfers on cycle T, PROC SHALL span T+1..T+64, UPDATE SHALL be T+65, and digest SHALL show the new H from T+66.
REQ-023 If the block's last=1: done SHALL pulse on T+66 and digest_valid SHALL be set on T+66.
REQ-024 If the block's last=0: done SHALL NOT pulse, and digest_valid SHALL stay unchanged.
REQ-025 digest_valid SHALL clear on the W0 transfer of any new block.
REQ-026 first=1 on a non-first block SHALL discard the prior chaining state.
REQ-027 first=0 when no prior block exists since reset SHALL chain from IV.
REQ-028 When SHA224=1:
- H SHALL initialise to the SHA-224 IV.
- digest[255:32] SHALL carry H0..H6.
- digest[31:0] SHALL read 0.
REQ-029 Padding SHALL NOT be performed by the block; software supplies padded blocks.
REQ-030 Values of first and last sampled on W1..W15 SHALL be ignored.
REQ-031 din_valid while din_ready=0 SHALL be ignored, with no state change.

Reset
REQ-032 rst SHALL override all other inputs on the same edge.
REQ-033 After rst, the block SHALL be in IDLE with:
- word counter = 0 and round counter = 0;
- H = IV per SHA224;
- din_ready = 1;
- busy = 0, done = 0, digest_valid = 0;
- digest = {H0..H7}, i.e. the IV per SHA224, with digest[31:0] = 0 when SHA224=1 (per REQ-011 and REQ-028).
REQ-034 rst asserted mid-LOAD or mid-PROC SHALL abandon the block; the next W0 SHALL start cleanly.

Verification
REQ-035 SHA-256 "abc" test: BYTE_SWAP=0, one padded block (61626380, 13 x 0, 00000018), first=1, last=1.
- Required: done on T+66.
- Required: digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-036 BYTE_SWAP=1 test: same block sent little-endian (80636261, ..., 18000000) -> identical digest to REQ-035.
REQ-037 SHA224=1 "abc" test.
- Required: digest[255:32] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
- Required: digest[31:0] = 0.
REQ-038 Two-block test: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", block 1 first=1/last=0, block 2 first=0/last=1.
- Required: no done after block 1.
- Required: done after block 2 with digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-039 Stall and back-pressure test: random din_valid gaps during LOAD, and din_valid held high during PROC.
- Required: din_ready=0 throughout PROC and UPDATE.
- Required: digest identical to REQ-035.
REQ-040 Reset-recovery test: rst pulsed at PROC round 30, then the "abc" block resent.
- Required: done=0 and digest_valid=0 after the reset.
- Required: correct digest as in REQ-035.

Source files
------------

// File: rtl/sha256_stream.sv
// rtl/sha256_stream.sv - streaming SHA-256/SHA-224 block compressor, one round per cycle
//
// Purpose: accepts pre-padded 512-bit message blocks as sixteen 32-bit words
// and folds each block into the running chaining value. The block is compressed
// with one round per cycle. Software pads the message and marks the first and
// last blocks.
//
// Ports:
//   clk          in   1    rising-edge clock
//   rst          in   1    synchronous active-high reset
//   din_valid    in   1    input word valid
//   din_ready    out  1    word accepted this cycle when din_valid is also high
//   din          in   32   message word, W0 first
//   first        in   1    with W0: start a new message from the IV
//   last         in   1    with W0: this block ends the message
//   digest       out  256  {H0..H7}, H0 in [255:224] (SHA-224: H7 slot reads 0)
//   digest_valid out  1    digest holds a completed message hash
//   busy         out  1    compressing or updating
//   done         out  1    one-cycle pulse when a last block completes
module sha256_stream #(
  parameter bit BYTE_SWAP = 1'b1,
  parameter bit SHA224    = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [31:0]  din,
  input  logic         first,
  input  logic         last,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_PROC   = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  localparam logic [255:0] IV = SHA224 ?
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4 :
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] iv_word(input int i);
    return IV[(7 - i) * 32 +: 32];
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [5:0]  rcnt_q, rcnt_d;
  logic        last_q, last_d;
  logic        dv_q, dv_d;
  logic        done_q, done_d;
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  logic [31:0] v_q [8];
  logic [31:0] v_d [8];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];

  logic        xfer;
  logic [31:0] word;
  logic [31:0] t1, t2, w_next;

  // Ready depends on registered state only, so valid never feeds back into ready.
  assign din_ready    = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy         = (state_q == S_PROC) || (state_q == S_UPDATE);
  assign xfer         = din_valid && din_ready;
  assign word         = BYTE_SWAP ? {din[7:0], din[15:8], din[23:16], din[31:24]} : din;
  assign digest_valid = dv_q;
  assign done         = done_q;
  assign digest       = SHA224 ?
    {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], 32'h0} :
    {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

  // Round datapath. w_q[0] is always W[t]; w_next is W[t+16], built from the
  // window positions holding W[t+14], W[t+9], W[t+1] and W[t].
  always_comb begin
    t1 = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
       + K_TABLE[rcnt_q] + w_q[0];
    t2 = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    w_next = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    last_d  = last_q;
    dv_d    = dv_q;
    done_d  = 1'b0;
    h_d     = h_q;
    v_d     = v_q;
    w_d     = w_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          w_d[0]  = word;
          wcnt_d  = 4'd1;
          last_d  = last;
          dv_d    = 1'b0;
          state_d = S_LOAD;
          // A new message restarts both the working set and the chaining
          // value so the final H + v sum is taken against the IV.
          for (int i = 0; i < 8; i++) begin
            v_d[i] = first ? iv_word(i) : h_q[i];
            if (first) h_d[i] = iv_word(i);
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          w_d[wcnt_q] = word;
          if (wcnt_q == 4'd15) begin
            wcnt_d  = 4'd0;
            rcnt_d  = 6'd0;
            state_d = S_PROC;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end
      end
      S_PROC: begin
        v_d[0] = t1 + t2;
        v_d[1] = v_q[0];
        v_d[2] = v_q[1];
        v_d[3] = v_q[2];
        v_d[4] = v_q[3] + t1;
        v_d[5] = v_q[4];
        v_d[6] = v_q[5];
        v_d[7] = v_q[6];
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
        w_d[15] = w_next;
        rcnt_d  = rcnt_q + 6'd1;
        if (rcnt_q == 6'd63) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
        if (last_q) begin
          done_d = 1'b1;
          dv_d   = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      rcnt_q  <= 6'd0;
      last_q  <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= iv_word(i);
        v_q[i] <= 32'h0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      last_q  <= last_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= h_d[i];
        v_q[i] <= v_d[i];
      end
      for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
    end
  end

endmodule

// File: tb/tb_sha256_stream.sv
// tb/tb_sha256_stream.sv - self-checking bench for sha256_stream
module tb_sha256_stream;

  localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] D_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_00000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        din_valid;
  logic [31:0] din;
  logic        first, last;
  int          sel;
  logic        v0, v1, v2;
  logic        rdy [3];
  logic        bsy [3];
  logic        dn  [3];
  logic        dvl [3];
  logic [255:0] dg [3];
  logic        cur_ready, cur_busy, cur_done, cur_dv;
  logic [255:0] cur_digest;

  logic [31:0]  blk [16];
  logic [255:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  assign v0 = din_valid && (sel == 0);
  assign v1 = din_valid && (sel == 1);
  assign v2 = din_valid && (sel == 2);

  sha256_stream #(.BYTE_SWAP(1'b0), .SHA224(1'b0)) u_be (
    .clk(clk), .rst(rst), .din_valid(v0), .din_ready(rdy[0]), .din(din),
    .first(first), .last(last), .digest(dg[0]), .digest_valid(dvl[0]),
    .busy(bsy[0]), .done(dn[0]));

  sha256_stream #(.BYTE_SWAP(1'b1), .SHA224(1'b0)) u_le (
    .clk(clk), .rst(rst), .din_valid(v1), .din_ready(rdy[1]), .din(din),
    .first(first), .last(last), .digest(dg[1]), .digest_valid(dvl[1]),
    .busy(bsy[1]), .done(dn[1]));

  sha256_stream #(.BYTE_SWAP(1'b0), .SHA224(1'b1)) u_224 (
    .clk(clk), .rst(rst), .din_valid(v2), .din_ready(rdy[2]), .din(din),
    .first(first), .last(last), .digest(dg[2]), .digest_valid(dvl[2]),
    .busy(bsy[2]), .done(dn[2]));

  always_comb begin
    case (sel)
      1:       begin cur_ready = rdy[1]; cur_busy = bsy[1]; cur_done = dn[1]; cur_dv = dvl[1]; cur_digest = dg[1]; end
      2:       begin cur_ready = rdy[2]; cur_busy = bsy[2]; cur_done = dn[2]; cur_dv = dvl[2]; cur_digest = dg[2]; end
      default: begin cur_ready = rdy[0]; cur_busy = bsy[0]; cur_done = dn[0]; cur_dv = dvl[0]; cur_digest = dg[0]; end
    endcase
  end

  task automatic set_abc(input bit le);
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = le ? 32'h80636261 : 32'h61626380;
    blk[15] = le ? 32'h18000000 : 32'h00000018;
  endtask

  task automatic set_two(input int part);
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    if (part == 1) begin
      blk[0]  = 32'h61626364; blk[1]  = 32'h62636465; blk[2]  = 32'h63646566;
      blk[3]  = 32'h64656667; blk[4]  = 32'h65666768; blk[5]  = 32'h66676869;
      blk[6]  = 32'h6768696a; blk[7]  = 32'h68696a6b; blk[8]  = 32'h696a6b6c;
      blk[9]  = 32'h6a6b6c6d; blk[10] = 32'h6b6c6d6e; blk[11] = 32'h6c6d6e6f;
      blk[12] = 32'h6d6e6f70; blk[13] = 32'h6e6f7071; blk[14] = 32'h80000000;
    end else begin
      blk[15] = 32'h000001c0;
    end
  endtask

  // Drives one block; returns #1 into cycle T+1 where T is the W15 transfer cycle.
  task automatic send_block(input bit f, input bit l, input bit gaps, input bit hold);
    bit not_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        din_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      din_valid = 1'b1;
      din       = blk[i];
      first     = (i == 0) ? f : 1'($urandom_range(0, 1));
      last      = (i == 0) ? l : 1'($urandom_range(0, 1));
      if (cur_ready !== 1'b1) not_ready = 1'b1;
      @(posedge clk); #1;
      if (i == 0) begin
        checks++;
        if (cur_dv !== 1'b0) begin
          errors++;
          $display("FAIL dv_clear_on_w0: got %b want 0", cur_dv);
        end
      end
    end
    if (hold) din = 32'hdeadbeef;
    else din_valid = 1'b0;
    checks++;
    if (not_ready) begin
      errors++;
      $display("FAIL ready_in_load: din_ready low during LOAD, want 1");
    end
  endtask

  // Walks cycles T+1..T+66 and checks the processing window and completion.
  task automatic wait_done(input bit exp_done, input bit exp_dv, input string name);
    int bad_cyc = -1;
    logic [255:0] want;
    for (int n = 1; n <= 66; n++) begin
      if (n <= 65) begin
        if ({cur_busy, cur_ready, cur_done} !== 3'b100 && bad_cyc < 0) bad_cyc = n;
        if (n == 65) din_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    checks++;
    if (bad_cyc >= 0) begin
      errors++;
      $display("FAIL %s proc_window: busy/ready/done wrong at T+%0d, want 100", name, bad_cyc);
    end
    checks++;
    if (cur_done !== exp_done || cur_dv !== exp_dv || cur_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s at_T+66: done=%b dv=%b busy=%b want done=%b dv=%b busy=0",
               name, cur_done, cur_dv, cur_busy, exp_done, exp_dv);
    end
    if (exp_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard: done with no expected digest queued", name);
      end else begin
        want = exp_q.pop_front();
        if (cur_digest !== want) begin
          errors++;
          $display("FAIL %s digest: got %h want %h", name, cur_digest, want);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (cur_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse_width: got %b at T+67 want 0", name, cur_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({rdy[k], bsy[k], dn[k], dvl[k]} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_flags[%0d]: ready/busy/done/dv=%b%b%b%b want 1000", k, rdy[k], bsy[k], dn[k], dvl[k]);
      end
      checks++;
      if (dg[k] !== ((k == 2) ? IV224 : IV256)) begin
        errors++;
        $display("FAIL reset_digest[%0d]: got %h want %h", k, dg[k], (k == 2) ? IV224 : IV256);
      end
    end
  endtask

  task automatic test_abc_be();
    sel = 0; set_abc(1'b0); exp_q.push_back(D_ABC);
    send_block(1'b1, 1'b1, 1'b0, 1'b0);
    wait_done(1'b1, 1'b1, "abc_be");
  endtask

  task automatic test_abc_le();
    sel = 1; set_abc(1'b1); exp_q.push_back(D_ABC);
    send_block(1'b1, 1'b1, 1'b0, 1'b0);
    wait_done(1'b1, 1'b1, "abc_le");
  endtask

  task automatic test_sha224();
    sel = 2; set_abc(1'b0); exp_q.push_back(D_224);
    send_block(1'b1, 1'b1, 1'b0, 1'b0);
    wait_done(1'b1, 1'b1, "sha224");
  endtask

  task automatic test_two_block();
    sel = 0; set_two(1);
    send_block(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, 1'b0, "two_blk1");
    set_two(2); exp_q.push_back(D_TWO);
    send_block(1'b0, 1'b1, 1'b0, 1'b0);
    wait_done(1'b1, 1'b1, "two_blk2");
  endtask

  task automatic test_first_discard();
    sel = 0; set_two(1);
    send_block(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, 1'b0, "discard_pre");
    set_abc(1'b0); exp_q.push_back(D_ABC);
    send_block(1'b1, 1'b1, 1'b0, 1'b0);
    wait_done(1'b1, 1'b1, "discard_abc");
  endtask

  task automatic test_stall();
    sel = 0; set_abc(1'b0); exp_q.push_back(D_ABC);
    send_block(1'b1, 1'b1, 1'b1, 1'b1);
    wait_done(1'b1, 1'b1, "stall");
  endtask

  task automatic test_reset_recovery();
    sel = 0; set_abc(1'b0);
    send_block(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (30) begin @(posedge clk); #1; end
    checks++;
    if (cur_busy !== 1'b1) begin
      errors++;
      $display("FAIL rr_mid_proc: busy=%b want 1", cur_busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({cur_done, cur_dv, cur_busy, cur_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL rr_after_reset: done/dv/busy/ready=%b%b%b%b want 0001", cur_done, cur_dv, cur_busy, cur_ready);
    end
    exp_q.push_back(D_ABC);
    send_block(1'b1, 1'b1, 1'b0, 1'b0);
    wait_done(1'b1, 1'b1, "rr_abc");
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = 32'h0; first = 1'b0; last = 1'b0; sel = 0;
    #1;
    test_reset();
    test_abc_be();
    test_abc_le();
    test_sha224();
    test_two_block();
    test_first_discard();
    test_stall();
    test_reset_recovery();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected digests left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
